// File: rtl/adt7420_poll_ctrl_pkg.sv
// Shared state encoding, ADT7420 register map and timing constants for the
// temperature polling controller.
package adt7420_poll_ctrl_pkg;

  localparam int unsigned TMR_W = 24;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG_REQ   = 3'd1,
    CFG_WAIT  = 3'd2,
    POLL_WAIT = 3'd3,
    RD_REQ    = 3'd4,
    RD_WAIT   = 3'd5,
    BACKOFF   = 3'd6,
    FAULT     = 3'd7
  } state_e;

  localparam logic [7:0]       REG_TEMP_MSB   = 8'h00;
  localparam logic [7:0]       REG_CONFIG     = 8'h03;
  localparam logic [TMR_W-1:0] BACKOFF_CYCLES = 24'd1024;

  // The timer is loaded on state entry, so N cycles of residence needs N-1.
  function automatic logic [TMR_W-1:0] cycles_to_load(input logic [TMR_W-1:0] cycles);
    if (cycles == 24'd0) begin
      return 24'd0;
    end else begin
      return cycles - 24'd1;
    end
  endfunction

endpackage

// File: rtl/adt7420_poll_timer.sv
// Loadable down-counter shared by the poll interval, backoff and transaction
// timeout; o_done is high while the count sits at zero.
module adt7420_poll_timer
  import adt7420_poll_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_done
);

  logic [TMR_W-1:0] r_count;

  // Count register: load wins, otherwise decrement down to zero and hold
  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != 24'd0) begin
      r_count <= r_count - 24'd1;
    end
  end

  assign o_done = (r_count == 24'd0);

endmodule

// File: rtl/adt7420_poll_ctrl.sv
// ADT7420 polling controller: configures 16-bit mode, then periodically reads
// the temperature through a generic I2C master, with retry/backoff and fault.
module adt7420_poll_ctrl
  import adt7420_poll_ctrl_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR    = 7'h4B,
  parameter logic [7:0]  CFG_VALUE   = 8'h80,
  parameter logic [23:0] POLL_CYCLES = 24'd10_000_000,
  parameter int unsigned MAX_RETRY   = 2,
  parameter logic [19:0] TXN_TIMEOUT = 20'd200_000
) (
  input  logic        i_clk,
  input  logic        reset_n,
  input  logic        i_enable,
  output logic [7:0]  o_addr_w_rw,
  output logic [15:0] o_sub_addr,
  output logic        o_sub_len,
  output logic [23:0] o_byte_len,
  output logic [7:0]  o_data_write,
  output logic        o_req_trans,
  input  logic [7:0]  i_data_out,
  input  logic        i_valid_out,
  input  logic        i_req_data_chunk,
  input  logic        i_busy,
  input  logic        i_nack,
  output logic [15:0] o_temp,
  output logic        o_temp_valid,
  output logic        o_fault,
  output logic [7:0]  o_err_cnt
);

  localparam logic [7:0] LP_MAX_RETRY = 8'(MAX_RETRY);

  state_e           r_state, w_next, w_nxt_fsm, w_fail_tgt;
  logic             r_busy_d, r_nack_seen, r_is_rd;
  logic [1:0]       r_vcnt, w_vcnt_nxt;
  logic [15:0]      r_shadow, w_shadow_nxt, r_temp, r_sub_addr;
  logic [7:0]       r_err_cnt, r_retry, r_addr_w_rw, r_data_write;
  logic [23:0]      r_byte_len;
  logic             r_sub_len, r_req_trans, r_temp_valid, r_fault;
  logic             w_fall, w_nack_any, w_in_rd, w_in_txn, w_strobe, w_stop;
  logic             w_succ, w_rd_succ, w_fail, w_enter_req;
  logic             w_tmr_load, w_tmr_done;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_unused;

  // Single-byte config write: the master's next-byte request needs no answer.
  assign w_unused    = i_req_data_chunk;

  assign w_fall      = r_busy_d & ~i_busy;
  assign w_nack_any  = r_nack_seen | i_nack;
  assign w_in_rd     = (r_state == RD_REQ) || (r_state == RD_WAIT);
  assign w_in_txn    = w_in_rd || (r_state == CFG_REQ) || (r_state == CFG_WAIT);
  assign w_strobe    = i_valid_out & w_in_rd;
  assign w_vcnt_nxt  = (w_strobe && (r_vcnt != 2'd3)) ? (r_vcnt + 2'd1) : r_vcnt;
  assign w_fail_tgt  = (r_retry >= LP_MAX_RETRY) ? FAULT : BACKOFF;
  assign w_stop      = (r_state != FAULT) && !i_enable && !i_busy;
  assign w_next      = w_stop ? IDLE : w_nxt_fsm;
  assign w_enter_req = ((w_next == CFG_REQ) || (w_next == RD_REQ)) && (w_next != r_state);
  assign w_tmr_load  = (w_next != r_state);

  // Read bytes land MSB first; strobes beyond the second are dropped
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_strobe && (r_vcnt == 2'd0)) begin
      w_shadow_nxt = {i_data_out, r_shadow[7:0]};
    end else if (w_strobe && (r_vcnt == 2'd1)) begin
      w_shadow_nxt = {r_shadow[15:8], i_data_out};
    end else begin
      w_shadow_nxt = r_shadow;
    end
  end

  // Next-state decode and transaction outcome
  always_comb begin
    w_nxt_fsm = r_state;
    w_succ    = 1'b0;
    w_rd_succ = 1'b0;
    w_fail    = 1'b0;
    case (r_state)
      IDLE:      w_nxt_fsm = i_enable ? CFG_REQ : IDLE;
      CFG_REQ, RD_REQ: begin
        if (i_busy) begin
          w_nxt_fsm = (r_state == CFG_REQ) ? CFG_WAIT : RD_WAIT;
        end else if (w_tmr_done) begin
          w_fail    = 1'b1;
          w_nxt_fsm = w_fail_tgt;
        end else begin
          w_nxt_fsm = r_state;
        end
      end
      CFG_WAIT: begin
        if (w_fall && !w_nack_any) begin
          w_succ    = 1'b1;
          w_nxt_fsm = RD_REQ;
        end else if (w_fall || w_tmr_done) begin
          w_fail    = 1'b1;
          w_nxt_fsm = w_fail_tgt;
        end else begin
          w_nxt_fsm = CFG_WAIT;
        end
      end
      RD_WAIT: begin
        if (w_fall && !w_nack_any && (w_vcnt_nxt == 2'd2)) begin
          w_succ    = 1'b1;
          w_rd_succ = 1'b1;
          w_nxt_fsm = POLL_WAIT;
        end else if (w_fall || w_tmr_done) begin
          w_fail    = 1'b1;
          w_nxt_fsm = w_fail_tgt;
        end else begin
          w_nxt_fsm = RD_WAIT;
        end
      end
      POLL_WAIT: w_nxt_fsm = w_tmr_done ? RD_REQ : POLL_WAIT;
      BACKOFF:   w_nxt_fsm = w_tmr_done ? (r_is_rd ? RD_REQ : CFG_REQ) : BACKOFF;
      FAULT:     w_nxt_fsm = i_enable ? FAULT : IDLE;
      default:   w_nxt_fsm = IDLE;
    endcase
  end

  // Timer reload value for the state being entered
  always_comb begin
    case (w_next)
      POLL_WAIT:                          w_tmr_val = cycles_to_load(POLL_CYCLES);
      BACKOFF:                            w_tmr_val = cycles_to_load(BACKOFF_CYCLES);
      CFG_REQ, CFG_WAIT, RD_REQ, RD_WAIT: w_tmr_val = cycles_to_load({4'd0, TXN_TIMEOUT});
      default:                            w_tmr_val = 24'd0;
    endcase
  end

  adt7420_poll_timer u_timer (
    .i_clk      (i_clk),
    .reset_n    (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // State, transaction tracking and registered outputs
  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_busy_d     <= 1'b0;
      r_nack_seen  <= 1'b0;
      r_vcnt       <= 2'd0;
      r_shadow     <= 16'h0000;
      r_is_rd      <= 1'b0;
      r_retry      <= 8'd0;
      r_err_cnt    <= 8'd0;
      r_req_trans  <= 1'b0;
      r_fault      <= 1'b0;
      r_temp       <= 16'h0000;
      r_temp_valid <= 1'b0;
      r_addr_w_rw  <= {I2C_ADDR, 1'b0};
      r_sub_addr   <= 16'h0000;
      r_sub_len    <= 1'b0;
      r_byte_len   <= 24'd0;
      r_data_write <= 8'h00;
    end else begin
      r_state      <= w_next;
      r_busy_d     <= i_busy;
      r_req_trans  <= (w_next == CFG_REQ) || (w_next == RD_REQ);
      r_fault      <= (w_next == FAULT);
      r_temp_valid <= w_rd_succ;
      if (w_rd_succ) begin
        r_temp <= w_shadow_nxt;
      end
      if (w_enter_req) begin
        r_nack_seen <= 1'b0;
        r_vcnt      <= 2'd0;
        r_shadow    <= 16'h0000;
      end else begin
        r_nack_seen <= r_nack_seen | (i_nack & w_in_txn);
        r_vcnt      <= w_vcnt_nxt;
        r_shadow    <= w_shadow_nxt;
      end
      if (w_next == CFG_REQ) begin
        r_is_rd      <= 1'b0;
        r_addr_w_rw  <= {I2C_ADDR, 1'b0};
        r_sub_addr   <= {8'h00, REG_CONFIG};
        r_sub_len    <= 1'b0;
        r_byte_len   <= 24'd1;
        r_data_write <= CFG_VALUE;
      end else if (w_next == RD_REQ) begin
        r_is_rd      <= 1'b1;
        r_addr_w_rw  <= {I2C_ADDR, 1'b1};
        r_sub_addr   <= {8'h00, REG_TEMP_MSB};
        r_sub_len    <= 1'b0;
        r_byte_len   <= 24'd2;
        r_data_write <= CFG_VALUE;
      end
      if (w_fail && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_succ || (w_next == IDLE)) begin
        r_retry <= 8'd0;
      end else if (w_fail) begin
        r_retry <= r_retry + 8'd1;
      end
    end
  end

  assign o_addr_w_rw  = r_addr_w_rw;
  assign o_sub_addr   = r_sub_addr;
  assign o_sub_len    = r_sub_len;
  assign o_byte_len   = r_byte_len;
  assign o_data_write = r_data_write;
  assign o_req_trans  = r_req_trans;
  assign o_temp       = r_temp;
  assign o_temp_valid = r_temp_valid;
  assign o_fault      = r_fault;
  assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_adt7420_poll_ctrl.sv
// Directed bench for adt7420_poll_ctrl with a task-driven I2C master model;
// short poll interval and timeout keep the run small.
module tb_adt7420_poll_ctrl;

  logic        i_clk = 1'b0;
  logic        reset_n;
  logic        i_enable;
  logic [7:0]  o_addr_w_rw;
  logic [15:0] o_sub_addr;
  logic        o_sub_len;
  logic [23:0] o_byte_len;
  logic [7:0]  o_data_write;
  logic        o_req_trans;
  logic [7:0]  i_data_out;
  logic        i_valid_out;
  logic        i_req_data_chunk;
  logic        i_busy;
  logic        i_nack;
  logic [15:0] o_temp;
  logic        o_temp_valid;
  logic        o_fault;
  logic [7:0]  o_err_cnt;

  int checks = 0;
  int errors = 0;

  adt7420_poll_ctrl #(
    .POLL_CYCLES (24'd1000),
    .TXN_TIMEOUT (20'd300)
  ) dut (
    .i_clk            (i_clk),
    .reset_n          (reset_n),
    .i_enable         (i_enable),
    .o_addr_w_rw      (o_addr_w_rw),
    .o_sub_addr       (o_sub_addr),
    .o_sub_len        (o_sub_len),
    .o_byte_len       (o_byte_len),
    .o_data_write     (o_data_write),
    .o_req_trans      (o_req_trans),
    .i_data_out       (i_data_out),
    .i_valid_out      (i_valid_out),
    .i_req_data_chunk (i_req_data_chunk),
    .i_busy           (i_busy),
    .i_nack           (i_nack),
    .o_temp           (o_temp),
    .o_temp_valid     (o_temp_valid),
    .o_fault          (o_fault),
    .o_err_cnt        (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!o_req_trans && (i < budget)) begin
      tick();
      i++;
    end
    ok = o_req_trans;
  endtask

  // Master model: accept the pending request and run one transaction.
  task automatic serve(input bit is_rd, input bit nack, input logic [7:0] b0, input logic [7:0] b1);
    i_busy = 1'b1;
    tick();
    tick();
    if (nack) begin
      i_nack = 1'b1;
      tick();
      i_nack = 1'b0;
    end
    if (is_rd && !nack) begin
      i_req_data_chunk = 1'b1;
      i_data_out  = b0;
      i_valid_out = 1'b1;
      tick();
      i_valid_out = 1'b0;
      i_req_data_chunk = 1'b0;
      tick();
      i_data_out  = b1;
      i_valid_out = 1'b1;
      tick();
      i_valid_out = 1'b0;
    end
    tick();
    i_busy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_enable = 1'b0; i_busy = 1'b0; i_nack = 1'b0;
    i_valid_out = 1'b0; i_data_out = 8'h00; i_req_data_chunk = 1'b0;
    tick();
    tick();
    checks++;
    if ({o_req_trans, o_temp_valid, o_fault, o_sub_len} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {o_req_trans, o_temp_valid, o_fault, o_sub_len});
    end
    checks++;
    if ({o_temp, o_err_cnt} !== 24'h000000) begin
      errors++; $display("FAIL reset_temp_err got %h want 000000", {o_temp, o_err_cnt});
    end
    checks++;
    if ({o_addr_w_rw, o_sub_addr, o_byte_len, o_data_write} !== {8'h96, 16'h0000, 24'd0, 8'h00}) begin
      errors++; $display("FAIL reset_fields got %h", {o_addr_w_rw, o_sub_addr, o_byte_len, o_data_write});
    end
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if (o_req_trans !== 1'b0) begin
      errors++; $display("FAIL idle_no_req got %b want 0", o_req_trans);
    end
  endtask

  task automatic test_cfg_then_read();
    bit ok;
    i_enable = 1'b1;
    wait_req(20, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL cfg_req_seen got %b want 1", ok); end
    checks++;
    if ({o_addr_w_rw, o_sub_addr, o_sub_len, o_byte_len, o_data_write} !== {8'h96, 16'h0003, 1'b0, 24'd1, 8'h80}) begin
      errors++; $display("FAIL cfg_fields got %h", {o_addr_w_rw, o_sub_addr, o_sub_len, o_byte_len, o_data_write});
    end
    serve(1'b0, 1'b0, 8'h00, 8'h00);
    wait_req(20, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rd_req_seen got %b want 1", ok); end
    checks++;
    if ({o_addr_w_rw, o_sub_addr, o_sub_len, o_byte_len} !== {8'h97, 16'h0000, 1'b0, 24'd2}) begin
      errors++; $display("FAIL rd_fields got %h", {o_addr_w_rw, o_sub_addr, o_sub_len, o_byte_len});
    end
    serve(1'b1, 1'b0, 8'h0C, 8'h80);
    checks++;
    if ({o_temp_valid, o_temp} !== {1'b1, 16'h0C80}) begin
      errors++; $display("FAIL first_temp got %h want 10c80", {o_temp_valid, o_temp});
    end
    tick();
    checks++;
    if ({o_temp_valid, o_err_cnt} !== {1'b0, 8'd0}) begin
      errors++; $display("FAIL valid_pulse_width got %h want 000", {o_temp_valid, o_err_cnt});
    end
  endtask

  // Entered one cycle after the o_temp_valid pulse.
  task automatic test_poll_interval();
    int n;
    n = 1;
    while (!o_req_trans && (n < 1200)) begin tick(); n++; end
    checks++;
    if (n !== 1000) begin errors++; $display("FAIL poll_interval got %0d want 1000", n); end
    serve(1'b1, 1'b0, 8'h19, 8'h40);
    checks++;
    if ({o_temp_valid, o_temp} !== {1'b1, 16'h1940}) begin
      errors++; $display("FAIL second_temp got %h want 11940", {o_temp_valid, o_temp});
    end
  endtask

  task automatic test_nack_retry();
    bit ok;
    int n;
    tick();
    wait_req(1100, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL nack_req_seen got %b want 1", ok); end
    serve(1'b1, 1'b1, 8'h00, 8'h00);
    checks++;
    if ({o_err_cnt, o_temp_valid, o_temp, o_req_trans} !== {8'd1, 1'b0, 16'h1940, 1'b0}) begin
      errors++; $display("FAIL nack_effect got %h want 01 0 1940 0", {o_err_cnt, o_temp_valid, o_temp, o_req_trans});
    end
    n = 0;
    while (!o_req_trans && (n < 1200)) begin tick(); n++; end
    checks++;
    if (n !== 1024) begin errors++; $display("FAIL backoff_len got %0d want 1024", n); end
    checks++;
    if (o_addr_w_rw !== 8'h97) begin errors++; $display("FAIL retry_is_read got %h want 97", o_addr_w_rw); end
    serve(1'b1, 1'b0, 8'h00, 8'h10);
    checks++;
    if ({o_temp_valid, o_temp} !== {1'b1, 16'h0010}) begin
      errors++; $display("FAIL retry_temp got %h want 10010", {o_temp_valid, o_temp});
    end
  endtask

  // Starts with o_err_cnt=1 from the previous NACK; a cleared retry counter
  // allows three attempts, leaving 1+3=4.
  task automatic test_persistent_nack();
    bit ok;
    int attempts;
    attempts = 0;
    for (int a = 0; a < 5; a++) begin
      wait_req(1100, ok);
      if (!ok) break;
      serve(1'b1, 1'b1, 8'h00, 8'h00);
      attempts++;
    end
    checks++;
    if (attempts !== 3) begin errors++; $display("FAIL attempts got %0d want 3", attempts); end
    checks++;
    if ({o_fault, o_req_trans, o_err_cnt} !== {1'b1, 1'b0, 8'd4}) begin
      errors++; $display("FAIL fault_state got %h want 2_04", {o_fault, o_req_trans, o_err_cnt});
    end
    i_enable = 1'b0;
    tick();
    tick();
    checks++;
    if ({o_fault, o_err_cnt} !== {1'b0, 8'd4}) begin
      errors++; $display("FAIL fault_clear got %h want 004", {o_fault, o_err_cnt});
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    reset_n = 1'b0;
    tick();
    reset_n  = 1'b1;
    i_enable = 1'b1;
    wait_req(20, ok);
    n = 0;
    while (o_req_trans && (n < 400)) begin tick(); n++; end
    checks++;
    if (n !== 300) begin errors++; $display("FAIL timeout_len got %0d want 300", n); end
    checks++;
    if ({o_err_cnt, o_fault} !== {8'd1, 1'b0}) begin
      errors++; $display("FAIL timeout_err got %h want 010", {o_err_cnt, o_fault});
    end
    n = 0;
    while (!o_req_trans && (n < 1200)) begin tick(); n++; end
    checks++;
    if (n !== 1024) begin errors++; $display("FAIL timeout_backoff got %0d want 1024", n); end
    checks++;
    if ({o_addr_w_rw, o_sub_addr} !== {8'h96, 16'h0003}) begin
      errors++; $display("FAIL timeout_reissue got %h want 960003", {o_addr_w_rw, o_sub_addr});
    end
    serve(1'b0, 1'b0, 8'h00, 8'h00);
    wait_req(20, ok);
    serve(1'b1, 1'b0, 8'h12, 8'h34);
    checks++;
    if ({o_temp_valid, o_temp} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL post_timeout_temp got %h want 11234", {o_temp_valid, o_temp});
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    tick();
    wait_req(1100, ok);
    i_busy = 1'b1;
    tick();
    tick();
    i_valid_out = 1'b1;
    i_data_out  = 8'hAA;
    tick();
    i_valid_out = 1'b0;
    reset_n = 1'b0;
    tick();
    checks++;
    if ({o_req_trans, o_temp_valid, o_fault, o_temp, o_err_cnt} !== {3'b000, 16'h0000, 8'd0}) begin
      errors++; $display("FAIL midrd_reset_status got %h want 0", {o_req_trans, o_temp_valid, o_fault, o_temp, o_err_cnt});
    end
    checks++;
    if ({o_addr_w_rw, o_sub_addr, o_byte_len, o_data_write} !== {8'h96, 16'h0000, 24'd0, 8'h00}) begin
      errors++; $display("FAIL midrd_reset_fields got %h", {o_addr_w_rw, o_sub_addr, o_byte_len, o_data_write});
    end
    i_enable = 1'b0;
    reset_n  = 1'b1;
    tick();
    i_busy = 1'b0;
    tick();
    tick();
    checks++;
    if (o_req_trans !== 1'b0) begin errors++; $display("FAIL midrd_idle got %b want 0", o_req_trans); end
    i_enable = 1'b1;
    wait_req(3, ok);
    checks++;
    if ({ok, o_addr_w_rw} !== {1'b1, 8'h96}) begin
      errors++; $display("FAIL midrd_restart got %h want 196", {ok, o_addr_w_rw});
    end
  endtask

  initial begin
    test_reset();
    test_cfg_then_read();
    test_poll_interval();
    test_nack_retry();
    test_persistent_nack();
    test_timeout();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
